// File: rtl/dmem_dump_reader.sv
// Data-memory read-back engine: walks a word-aligned range while the CPU
// is held in reset and streams each word out over a valid/ready port.
module dmem_dump_reader #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [31:0]       dout_data,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        FINISH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  remaining_nxt;
    logic              err_flag;
    logic              err_flag_nxt;
    logic              capture;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] daddr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            err_flag  <= 1'b0;
            data_q    <= '0;
            daddr_q   <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
            err_flag  <= err_flag_nxt;
            if (capture) begin
                data_q  <= mem_rdata;
                daddr_q <= addr;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        err_flag_nxt  = err_flag;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (base_addr[1:0] != 2'b00) begin
                        err_flag_nxt = 1'b1;
                        state_nxt    = FINISH;
                    end else if (word_count == '0) begin
                        err_flag_nxt = 1'b0;
                        state_nxt    = FINISH;
                    end else begin
                        err_flag_nxt  = 1'b0;
                        addr_nxt      = base_addr;
                        remaining_nxt = word_count;
                        state_nxt     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (dout_ready) begin
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = FINISH;
                    end else begin
                        // addr only moves on the way into FETCH
                        remaining_nxt = remaining - CNT_W'(1);
                        addr_nxt      = addr + ADDR_W'(4);
                        state_nxt     = FETCH;
                    end
                end
            end
            FINISH: begin
                err_flag_nxt = 1'b0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_re     = (state == FETCH);
    assign mem_addr   = addr;
    assign dout_valid = (state == HOLD);
    assign dout_data  = data_q;
    assign dout_addr  = daddr_q;
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign err        = (state == FINISH) && err_flag;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Randomized bench for dmem_dump_reader against a word-list model of
// the expected dump and its cycle timing.
module tb_dmem_dump_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        abort;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [31:0] dout_addr;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;
    logic [31:0] salt;

    dmem_dump_reader #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .abort     (abort),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_addr (dout_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a,
                                              input logic [31:0] s);
        if (s == 32'd0 && a == 32'h10) return 32'h11111111;
        if (s == 32'd0 && a == 32'h14) return 32'h22222222;
        if (s == 32'd0 && a == 32'h18) return 32'h33333333;
        return (a * 32'h9E3779B1) ^ s ^ 32'h5A5A0F0F;
    endfunction

    assign mem_rdata = mem_model(mem_addr, salt);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: ready high, 1: random ready, 2: 5-cycle stall on beat 1
    // abort_idx >= 0 aborts while that beat is being offered
    task automatic do_dump(input logic [31:0] base, input logic [15:0] cnt,
                           input int mode, input int abort_idx);
        int cyc;
        int idx;
        int want;
        int stall;
        logic [31:0] ea;
        logic rdy;
        bit bad;
        bad = (base[1:0] != 2'b00);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        dout_ready = 1'b0;
        step();
        start     = 1'b0;
        base_addr = $urandom;
        word_count = 16'($urandom);
        if (bad || cnt == 16'd0) begin
            check("short_done", done, 1'b1);
            check("short_err", err, bad);
            check("short_busy", busy, 1'b1);
            check("short_mem_re", mem_re, 1'b0);
            step();
            check("short_idle_busy", busy, 1'b0);
            check("short_done_off", done, 1'b0);
            check("short_mem_re2", mem_re, 1'b0);
            return;
        end
        cyc   = 1;
        idx   = 0;
        want  = 2;
        stall = 0;
        while (idx < int'(cnt)) begin
            if (cyc > 20 * int'(cnt) + 20) begin
                check("timeout", 1'b1, 1'b0);
                return;
            end
            ea = base + 32'(idx) * 32'd4;
            check("mem_re", mem_re, cyc == want - 1);
            if (cyc == want - 1) check("mem_addr", mem_addr, ea);
            check("valid", dout_valid, cyc >= want);
            check("busy", busy, 1'b1);
            check("done_mid", done, 1'b0);
            if (dout_valid && cyc >= want) begin
                check("data", dout_data, mem_model(ea, salt));
                check("addr", dout_addr, ea);
            end
            if (abort_idx == idx && dout_valid) begin
                abort      = 1'b1;
                dout_ready = 1'b0;
                step();
                abort = 1'b0;
                check("abort_valid", dout_valid, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_mem_re", mem_re, 1'b0);
                step();
                check("abort_done2", done, 1'b0);
                check("abort_err2", err, 1'b0);
                return;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom % 2);
                default: begin
                    rdy = 1'b1;
                    if (idx == 1 && dout_valid && stall < 5) begin
                        rdy = 1'b0;
                        stall++;
                    end
                end
            endcase
            dout_ready = rdy;
            if (dout_valid && rdy) begin
                idx++;
                want = cyc + 2;
            end
            step();
            cyc++;
        end
        dout_ready = 1'b0;
        check("end_done", done, 1'b1);
        check("end_err", err, 1'b0);
        check("end_busy", busy, 1'b1);
        check("end_valid", dout_valid, 1'b0);
        step();
        check("end_idle", busy, 1'b0);
        check("end_done_off", done, 1'b0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        salt       = 32'd0;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        dout_ready = 1'b0;
        @(negedge clk);
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_done", done, 1'b0);
        reset = 1'b1;
        step();

        do_dump(32'h10, 16'd3, 0, -1);
        do_dump(32'h10, 16'd3, 2, -1);
        do_dump(32'h10, 16'd0, 0, -1);
        do_dump(32'h12, 16'd3, 0, -1);
        salt = 32'h1234;
        do_dump(32'hFFFFFFFC, 16'd2, 0, -1);
        do_dump(32'h100, 16'd4, 0, 1);
        do_dump(32'h200, 16'd3, 1, -1);

        // reset pulse while the engine is in FETCH
        base_addr  = 32'h40;
        word_count = 16'd4;
        start      = 1'b1;
        step();
        start = 1'b0;
        check("pre_rst_mem_re", mem_re, 1'b1);
        reset = 1'b0;
        start = 1'b1;
        step();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_mem_re", mem_re, 1'b0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_ddata", dout_data, 32'd0);
        check("mid_rst_daddr", dout_addr, 32'd0);
        check("mid_rst_valid", dout_valid, 1'b0);
        reset = 1'b1;
        start = 1'b0;
        step();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic [31:0] b;
            salt = $urandom;
            b    = $urandom;
            if ($urandom % 5 != 0) b[1:0] = 2'b00;
            if ($urandom % 4 == 0) b = 32'hFFFFFFF0 | (b & 32'hC);
            do_dump(b, 16'($urandom % 7), 1, ($urandom % 6 == 0) ? 1 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
